// File: rtl/hub_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// hub_rr_arbiter_pkg
// Shared definitions for the hub schedulers: arbiter state encoding, the
// source-index width helper and the statistics counter width.
// -----------------------------------------------------------------------------
package hub_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // Width of a source index; never below one bit so a single-source
    // build still has a legal vector.
    function automatic int calc_src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hub_rr_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating first-one finder. Scans valid_vector starting at
// rr_ptr and wrapping modulo N; reports the first set position.
//
// Ports
//   valid_vector  in   N       request vector
//   rr_ptr        in   SRC_W   scan start position (must be < N)
//   grant_valid   out  1       at least one request present
//   grant_idx     out  SRC_W   index of the first request at or after rr_ptr
// -----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int N     = 3,
    parameter int SRC_W = 2
) (
    input  logic [N-1:0]     valid_vector,
    input  logic [SRC_W-1:0] rr_ptr,
    output logic             grant_valid,
    output logic [SRC_W-1:0] grant_idx
);

    // One extra bit so rr_ptr + k cannot overflow before the modulo fold.
    localparam logic [SRC_W:0] N_W = (SRC_W + 1)'(N);

    logic [SRC_W:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (!grant_valid && valid_vector[idx[SRC_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[SRC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/hub_rr_arbiter.sv
// -----------------------------------------------------------------------------
// hub_rr_arbiter
// Registered round-robin merge of TRUE_FIFO_COUNT hub FIFO streams into one
// downstream stream. A source keeps the grant for up to MAX_BURST consecutive
// words, then the grant rotates. A one-entry output register isolates the
// downstream stage.
//
// Optional feature macro: HUB_RR_ARBITER_STATS_EN adds one saturating 16-bit
// accepted-word counter per source on stat_count_vector.
//
// Ports
//   clk                in   1                 clock
//   reset              in   1                 synchronous, active-high
//   in_data_vector     in   N*W               source i at [(i+1)*W-1 : i*W]
//   in_valid_vector    in   N                 per-source valid
//   in_ready_vector    out  N                 per-source pop, one-hot or zero
//   out_valid          out  1                 registered output valid
//   out_data           out  W                 registered message
//   out_source         out  SRC_W             source of out_data
//   stat_count_vector  out  N*16              per-source counters (stats only)
//   out_ready          in   1                 downstream accept
//
// state | meaning
// IDLE  | no owner; next grant comes from the round-robin scan
// HOLD  | owner holds the grant while valid and burst_cnt < MAX_BURST
// -----------------------------------------------------------------------------
module hub_rr_arbiter
    import hub_rr_arbiter_pkg::*;
#(
    parameter int  HUB_FIFO_WIDTH  = 32,
    parameter int  TRUE_FIFO_COUNT = 3,
    parameter int  MAX_BURST       = 4,
    localparam int SRC_W           = calc_src_w(TRUE_FIFO_COUNT)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [TRUE_FIFO_COUNT*HUB_FIFO_WIDTH-1:0] in_data_vector,
    input  logic [TRUE_FIFO_COUNT-1:0]                in_valid_vector,
    output logic [TRUE_FIFO_COUNT-1:0]                in_ready_vector,
    output logic                                      out_valid,
    output logic [HUB_FIFO_WIDTH-1:0]                 out_data,
    output logic [SRC_W-1:0]                          out_source,
`ifdef HUB_RR_ARBITER_STATS_EN
    output logic [TRUE_FIFO_COUNT*STAT_W-1:0]         stat_count_vector,
`endif
    input  logic                                      out_ready
);

    localparam int                 BURST_W     = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
    localparam logic [SRC_W-1:0]   LAST_SRC    = SRC_W'(TRUE_FIFO_COUNT - 1);

    arb_state_t                state_q,      state_d;
    logic [SRC_W-1:0]          owner_q,      owner_d;
    logic [SRC_W-1:0]          rr_ptr_q,     rr_ptr_d;
    logic [BURST_W-1:0]        burst_q,      burst_d;
    logic                      out_valid_q,  out_valid_d;
    logic [HUB_FIFO_WIDTH-1:0] out_data_q,   out_data_d;
    logic [SRC_W-1:0]          out_source_q, out_source_d;

    logic                      pick_valid;
    logic [SRC_W-1:0]          pick_idx;
    logic                      hold_hit;
    logic                      grant_valid;
    logic [SRC_W-1:0]          grant;
    logic                      pipe_ready;
    logic                      xfer;
    logic [HUB_FIFO_WIDTH-1:0] sel_data;

    rr_priority_pick #(
        .N     (TRUE_FIFO_COUNT),
        .SRC_W (SRC_W)
    ) u_pick (
        .valid_vector (in_valid_vector),
        .rr_ptr       (rr_ptr_q),
        .grant_valid  (pick_valid),
        .grant_idx    (pick_idx)
    );

    // rr_ptr is always one past the owner, so the scan visits the current
    // owner last and a lone requester is re-granted after its burst.
    assign hold_hit    = (state_q == HOLD) && in_valid_vector[owner_q]
                         && (burst_q < BURST_LIMIT);
    assign grant       = hold_hit ? owner_q : pick_idx;
    assign grant_valid = hold_hit || pick_valid;
    assign pipe_ready  = !out_valid_q || out_ready;
    // Nothing is popped while reset is asserted.
    assign xfer        = pipe_ready && grant_valid && !reset;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < TRUE_FIFO_COUNT; i++) begin
            if (grant == SRC_W'(i)) begin
                sel_data = in_data_vector[i*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH];
            end
        end
    end

    always_comb begin
        in_ready_vector = '0;
        for (int i = 0; i < TRUE_FIFO_COUNT; i++) begin
            in_ready_vector[i] = xfer && (grant == SRC_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            burst_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_source_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            burst_q      <= burst_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_source_q <= out_source_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        burst_d      = burst_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_source_d = out_source_q;

        if (pipe_ready) begin
            if (xfer) begin
                out_valid_d  = 1'b1;
                out_data_d   = sel_data;
                out_source_d = grant;
                if (hold_hit) begin
                    burst_d = burst_q + BURST_W'(1);
                end else begin
                    state_d  = HOLD;
                    owner_d  = grant;
                    burst_d  = BURST_W'(1);
                    rr_ptr_d = (grant == LAST_SRC) ? '0 : grant + SRC_W'(1);
                end
            end else begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
                burst_d     = '0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_source = out_source_q;

`ifdef HUB_RR_ARBITER_STATS_EN
    logic [STAT_W-1:0] stat_q [TRUE_FIFO_COUNT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TRUE_FIFO_COUNT; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TRUE_FIFO_COUNT; i++) begin
                if (in_ready_vector[i] && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < TRUE_FIFO_COUNT; g++) begin : g_stat
        assign stat_count_vector[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_hub_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hub_rr_arbiter
// Directed bench for hub_rr_arbiter. Two instances share all inputs:
// dut_a uses MAX_BURST=4, dut_b uses MAX_BURST=2. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_hub_rr_arbiter;

    localparam int W = 32;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic           out_ready;

    logic [N-1:0]   rdy_a, rdy_b;
    logic           ov_a, ov_b;
    logic [W-1:0]   od_a, od_b;
    logic [1:0]     os_a, os_b;
`ifdef HUB_RR_ARBITER_STATS_EN
    logic [N*16-1:0] st_a, st_b;
`endif

    int vectors     = 0;
    int miscompares = 0;

    int seq_a [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    int seq_b [12] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2};
    int rel_a [8]  = '{1, 1, 1, 2, 2, 2, 2, 0};
    int rel_b [8]  = '{1, 2, 2, 0, 0, 1, 1, 2};

    logic [N-1:0]   oh;

    always #5 clk = ~clk;

    hub_rr_arbiter #(.HUB_FIFO_WIDTH(W), .TRUE_FIFO_COUNT(N), .MAX_BURST(4)) dut_a (
        .clk               (clk),
        .reset             (reset),
        .in_data_vector    (in_data),
        .in_valid_vector   (in_valid),
        .in_ready_vector   (rdy_a),
        .out_valid         (ov_a),
        .out_data          (od_a),
        .out_source        (os_a),
`ifdef HUB_RR_ARBITER_STATS_EN
        .stat_count_vector (st_a),
`endif
        .out_ready         (out_ready)
    );

    hub_rr_arbiter #(.HUB_FIFO_WIDTH(W), .TRUE_FIFO_COUNT(N), .MAX_BURST(2)) dut_b (
        .clk               (clk),
        .reset             (reset),
        .in_data_vector    (in_data),
        .in_valid_vector   (in_valid),
        .in_ready_vector   (rdy_b),
        .out_valid         (ov_b),
        .out_data          (od_b),
        .out_source        (os_b),
`ifdef HUB_RR_ARBITER_STATS_EN
        .stat_count_vector (st_b),
`endif
        .out_ready         (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [W-1:0] d);
        in_data[s*W +: W] = d;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        step();

        // Reset state
        check("rst_valid_a", 64'(ov_a), 64'd0);
        check("rst_data_a", 64'(od_a), 64'd0);
        check("rst_source_a", 64'(os_a), 64'd0);
        check("rst_ready_a", 64'(rdy_a), 64'd0);
        check("rst_valid_b", 64'(ov_b), 64'd0);

        // Idle for 10 cycles
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("idle_ready_a", 64'(rdy_a), 64'd0);
            step();
            check("idle_valid_a", 64'(ov_a), 64'd0);
        end
`ifdef HUB_RR_ARBITER_STATS_EN
        check("idle_stats_a", 64'(st_a), 64'd0);
`endif

        // Sole requester: source 1 streams 0x10..0x19
        for (int k = 0; k < 10; k++) begin
            in_valid = 3'b010;
            set_src(1, 32'h10 + k);
            #1;
            check("sole_ready_a", 64'(rdy_a), 64'b010);
            check("sole_ready_b", 64'(rdy_b), 64'b010);
            step();
            check("sole_valid_a", 64'(ov_a), 64'd1);
            check("sole_data_a", 64'(od_a), 64'(32'h10 + k));
            check("sole_source_a", 64'(os_a), 64'd1);
            check("sole_data_b", 64'(od_b), 64'(32'h10 + k));
        end
        in_valid = '0;
        #1;
        check("sole_end_ready_a", 64'(rdy_a), 64'd0);
        step();
        check("sole_end_valid_a", 64'(ov_a), 64'd0);

        // Full contention
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int s = 0; s < N; s++) set_src(s, 32'hA0 + s);
        in_valid = 3'b111;
        for (int i = 0; i < 12; i++) begin
            #1;
            oh = 3'b001 << seq_a[i];
            check("cont_ready_a", 64'(rdy_a), 64'(oh));
            oh = 3'b001 << seq_b[i];
            check("cont_ready_b", 64'(rdy_b), 64'(oh));
            step();
            check("cont_source_a", 64'(os_a), 64'(seq_a[i]));
            check("cont_data_a", 64'(od_a), 64'(32'hA0 + seq_a[i]));
            check("cont_source_b", 64'(os_b), 64'(seq_b[i]));
            check("cont_data_b", 64'(od_b), 64'(32'hA0 + seq_b[i]));
        end

        // Early release: source 0 drops valid after one word
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 3'b111;
        #1;
        check("rel_first_ready_a", 64'(rdy_a), 64'b001);
        step();
        check("rel_first_source_a", 64'(os_a), 64'd0);
        check("rel_first_source_b", 64'(os_b), 64'd0);
        check("rel_rr_ptr_a", 64'(dut_a.rr_ptr_q), 64'd1);
        in_valid = 3'b110;
        #1;
        check("rel_second_ready_a", 64'(rdy_a), 64'b010);
        check("rel_second_ready_b", 64'(rdy_b), 64'b010);
        step();
        check("rel_second_source_a", 64'(os_a), 64'd1);
        check("rel_second_source_b", 64'(os_b), 64'd1);
        in_valid = 3'b111;
        for (int i = 0; i < 8; i++) begin
            #1;
            oh = 3'b001 << rel_a[i];
            check("rel_ready_a", 64'(rdy_a), 64'(oh));
            step();
            check("rel_source_a", 64'(os_a), 64'(rel_a[i]));
            check("rel_source_b", 64'(os_b), 64'(rel_b[i]));
        end

        // Backpressure
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid  = 3'b001;
        out_ready = 1'b1;
        set_src(0, 32'h50);
        #1;
        check("bp_ready_a", 64'(rdy_a), 64'b001);
        step();
        check("bp_data0_a", 64'(od_a), 64'h50);
        out_ready = 1'b0;
        set_src(0, 32'h51);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_stall_ready_a", 64'(rdy_a), 64'd0);
            check("bp_stall_ready_b", 64'(rdy_b), 64'd0);
            step();
            check("bp_stall_valid_a", 64'(ov_a), 64'd1);
            check("bp_stall_data_a", 64'(od_a), 64'h50);
            check("bp_stall_source_a", 64'(os_a), 64'd0);
            check("bp_stall_data_b", 64'(od_b), 64'h50);
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_ready_a", 64'(rdy_a), 64'b001);
        step();
        check("bp_resume_data_a", 64'(od_a), 64'h51);
        check("bp_resume_data_b", 64'(od_b), 64'h51);
        set_src(0, 32'h52);
        step();
        check("bp_next_data_a", 64'(od_a), 64'h52);

        // Reset with a full output register and a pending request
        set_src(0, 32'h53);
        reset = 1'b1;
        #1;
        check("rst_mid_ready_a", 64'(rdy_a), 64'd0);
        step();
        check("rst_mid_valid_a", 64'(ov_a), 64'd0);
        check("rst_mid_data_a", 64'(od_a), 64'd0);
        reset = 1'b0;
        in_valid = '0;
        step();

`ifdef HUB_RR_ARBITER_STATS_EN
        // Saturating counters: 70000 words from source 2
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 3'b100;
        set_src(2, 32'hC0);
        for (int c = 0; c < 70000; c++) step();
        check("stat_sat_a", 64'(st_a[47:32]), 64'hFFFF);
        check("stat_others_a", 64'(st_a[31:0]), 64'd0);
        check("stat_sat_b", 64'(st_b[47:32]), 64'hFFFF);
        reset = 1'b1;
        step();
        check("stat_clear_a", 64'(st_a), 64'd0);
        check("stat_clear_valid_a", 64'(ov_a), 64'd0);
        reset = 1'b0;
        in_valid = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
